control_subcmd_fillarea_clip: RTL and testbench

Downstream write engine for rectangle-fill commands. The command-capture stage supplies a latched rectangle (x1, y1, width, height) and a colour. This block clips the rectangle to the panel bounds, then walks it row-major, issuing one framebuffer RAM byte-write per clock. It reports completion with a held done flag, which is released by the parent's ack pulse.

---
 rtl/control_subcmd_fillarea_clip.sv | 243 ++++++++++++++++++++++++
 tb/tb_control_subcmd_fillarea_clip.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_subcmd_fillarea_clip.sv
// rtl/control_subcmd_fillarea_clip.sv - clipped rectangle fill write engine
//
// Purpose:
//   Captures a rectangle (x1, y1, width, height) and a fill colour. It clips
//   the rectangle to the panel and then walks it row-major, issuing one
//   framebuffer byte-write per clock. Completion is reported on a held done
//   flag, which the parent releases with an ack pulse.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enable            level start request, held for the whole operation
//   ack               one-cycle pulse, clears done
//   x1, y1            top-left corner of the rectangle
//   width, height     rectangle size in columns / rows
//   color             fill colour, byte k = color[k*8+:8]
//   row, column       write address
//   pixel             byte index within the pixel being written
//   data_out          write data byte
//   ram_write_enable  write strobe, one byte per asserted cycle
//   ram_access_start  pulse on the first write of an operation
//   done              held from completion until ack

module control_subcmd_fillarea_clip #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  // Address widths leave room for the value PIXEL_WIDTH/PIXEL_HEIGHT itself,
  // so that out-of-panel coordinates and the exclusive end bound can be
  // represented.
  parameter int COL_W = $clog2(PIXEL_WIDTH + 1),
  parameter int ROW_W = $clog2(PIXEL_HEIGHT + 1),
  parameter int PIX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         ack,
  input  logic [COL_W-1:0]             x1,
  input  logic [ROW_W-1:0]             y1,
  input  logic [COL_W-1:0]             width,
  input  logic [ROW_W-1:0]             height,
  input  logic [BYTES_PER_PIXEL*8-1:0] color,
  output logic [ROW_W-1:0]             row,
  output logic [COL_W-1:0]             column,
  output logic [PIX_W-1:0]             pixel,
  output logic [7:0]                   data_out,
  output logic                         ram_write_enable,
  output logic                         ram_access_start,
  output logic                         done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLIP    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [COL_W-1:0] C_COL_LIM = COL_W'(PIXEL_WIDTH);
  localparam logic [ROW_W-1:0] C_ROW_LIM = ROW_W'(PIXEL_HEIGHT);
  localparam logic [PIX_W-1:0] C_PIX_TOP = PIX_W'(BYTES_PER_PIXEL - 1);

  logic [2:0]                   r_state;

  // Command captured on the IDLE->CLIP edge
  logic [COL_W-1:0]             r_x1;
  logic [ROW_W-1:0]             r_y1;
  logic [COL_W-1:0]             r_width;
  logic [ROW_W-1:0]             r_height;
  logic [BYTES_PER_PIXEL*8-1:0] r_color;

  // Clipped exclusive end bounds
  logic [COL_W-1:0]             r_x_end;
  logic [ROW_W-1:0]             r_y_end;

  // Walk cursor: the next byte to be written
  logic [ROW_W-1:0]             r_cur_row;
  logic [COL_W-1:0]             r_cur_col;
  logic [PIX_W-1:0]             r_cur_pix;
  logic                         r_first;

  // Registered outputs
  logic [ROW_W-1:0]             r_row;
  logic [COL_W-1:0]             r_column;
  logic [PIX_W-1:0]             r_pixel;
  logic [7:0]                   r_data;
  logic                         r_we;
  logic                         r_start;
  logic                         r_done;

  logic [COL_W:0]               w_x_sum;
  logic [ROW_W:0]               w_y_sum;
  logic [COL_W-1:0]             w_x_end;
  logic [ROW_W-1:0]             w_y_end;
  logic                         w_empty;
  logic [7:0]                   w_byte;
  logic [COL_W-1:0]             w_col_inc;
  logic [ROW_W-1:0]             w_row_inc;
  logic                         w_row_wrap;
  logic                         w_last;

  // Clip: sums carry one extra bit so a rectangle running past the panel
  // edge saturates at the edge instead of wrapping back into range.
  always_comb begin
    w_x_sum = {1'b0, r_x1} + {1'b0, r_width};
    w_y_sum = {1'b0, r_y1} + {1'b0, r_height};
    w_x_end = (w_x_sum > {1'b0, C_COL_LIM}) ? C_COL_LIM : w_x_sum[COL_W-1:0];
    w_y_end = (w_y_sum > {1'b0, C_ROW_LIM}) ? C_ROW_LIM : w_y_sum[ROW_W-1:0];
    w_empty = (r_width == '0) || (r_height == '0) ||
              (r_x1 >= C_COL_LIM) || (r_y1 >= C_ROW_LIM);
  end

  // Colour byte selected by the cursor's byte index
  always_comb begin
    w_byte = 8'h00;
    for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
      if (r_cur_pix == PIX_W'(k)) begin
        w_byte = r_color[k*8 +: 8];
      end
    end
  end

  // Cursor stepping. The cursor never exceeds PIXEL_WIDTH-1 / PIXEL_HEIGHT-1
  // while writing, so the increments cannot overflow the address widths.
  always_comb begin
    w_col_inc  = r_cur_col + 1'b1;
    w_row_inc  = r_cur_row + 1'b1;
    w_row_wrap = (r_cur_pix == '0) && (w_col_inc == r_x_end);
    w_last     = w_row_wrap && (w_row_inc == r_y_end);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x1      <= '0;
      r_y1      <= '0;
      r_width   <= '0;
      r_height  <= '0;
      r_color   <= '0;
      r_x_end   <= '0;
      r_y_end   <= '0;
      r_cur_row <= '0;
      r_cur_col <= '0;
      r_cur_pix <= '0;
      r_first   <= 1'b0;
      r_row     <= '0;
      r_column  <= '0;
      r_pixel   <= '0;
      r_data    <= '0;
      r_we      <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Outputs fall back to the idle values unless a state drives them.
      r_row    <= '0;
      r_column <= '0;
      r_pixel  <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_x1     <= x1;
            r_y1     <= y1;
            r_width  <= width;
            r_height <= height;
            r_color  <= color;
            r_state  <= S_CLIP;
          end
        end

        S_CLIP: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            r_x_end   <= w_x_end;
            r_y_end   <= w_y_end;
            r_cur_row <= r_y1;
            r_cur_col <= r_x1;
            r_cur_pix <= C_PIX_TOP;
            r_first   <= 1'b1;
            r_state   <= w_empty ? S_DONE : S_WRITE;
          end
        end

        S_WRITE: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else begin
            r_row    <= r_cur_row;
            r_column <= r_cur_col;
            r_pixel  <= r_cur_pix;
            r_data   <= w_byte;
            r_we     <= 1'b1;
            r_start  <= r_first;
            r_first  <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
            end else if (r_cur_pix != '0) begin
              r_cur_pix <= r_cur_pix - 1'b1;
            end else if (w_row_wrap) begin
              r_cur_pix <= C_PIX_TOP;
              r_cur_col <= r_x1;
              r_cur_row <= w_row_inc;
            end else begin
              r_cur_pix <= C_PIX_TOP;
              r_cur_col <= w_col_inc;
            end
          end
        end

        S_DONE: begin
          // done holds until ack; enable alone does not leave this state.
          if (ack) begin
            r_state <= S_RELEASE;
          end else begin
            r_done <= 1'b1;
          end
        end

        S_RELEASE: begin
          // Waiting for enable to fall keeps a held enable from retriggering.
          if (!enable) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign row              = r_row;
  assign column           = r_column;
  assign pixel            = r_pixel;
  assign data_out         = r_data;
  assign ram_write_enable = r_we;
  assign ram_access_start = r_start;
  assign done             = r_done;

endmodule

// File: tb/tb_control_subcmd_fillarea_clip.sv
// tb/tb_control_subcmd_fillarea_clip.sv - directed bench for control_subcmd_fillarea_clip

module tb_control_subcmd_fillarea_clip;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        ack;
  logic [6:0]  x1;
  logic [5:0]  y1;
  logic [6:0]  width;
  logic [5:0]  height;
  logic [15:0] color;
  logic [5:0]  row;
  logic [6:0]  column;
  logic [0:0]  pixel;
  logic [7:0]  data_out;
  logic        ram_write_enable;
  logic        ram_access_start;
  logic        done;

  int checks = 0;
  int errors = 0;

  int n_wr;
  int n_start;
  int first_cyc;
  int start_cyc;
  int done_cyc;
  logic [31:0] wr_q[$];

  control_subcmd_fillarea_clip #(
    .BYTES_PER_PIXEL(2),
    .PIXEL_WIDTH(64),
    .PIXEL_HEIGHT(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ack(ack),
    .x1(x1),
    .y1(y1),
    .width(width),
    .height(height),
    .color(color),
    .row(row),
    .column(column),
    .pixel(pixel),
    .data_out(data_out),
    .ram_write_enable(ram_write_enable),
    .ram_access_start(ram_access_start),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_row"}, 32'(row), 32'd0);
    chk({tag, "_col"}, 32'(column), 32'd0);
    chk({tag, "_pix"}, 32'(pixel), 32'd0);
    chk({tag, "_data"}, 32'(data_out), 32'd0);
    chk({tag, "_we"}, 32'(ram_write_enable), 32'd0);
    chk({tag, "_start"}, 32'(ram_access_start), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Starts one fill, records every write until done, and compares against
  // an independent clip-and-walk model. Inputs are scrambled right after
  // the enable sample to show they are captured once.
  task automatic run_fill(input string tag, input int ax1, input int ay1,
                          input int aw, input int ah, input logic [15:0] acol);
    int xe, ye, n_exp, k;
    bit empty;
    logic [31:0] e;
    empty = (aw == 0) || (ah == 0) || (ax1 >= 64) || (ay1 >= 32);
    xe = (ax1 + aw > 64) ? 64 : ax1 + aw;
    ye = (ay1 + ah > 32) ? 32 : ay1 + ah;
    n_exp = empty ? 0 : (xe - ax1) * (ye - ay1) * 2;

    @(negedge clk);
    x1 = 7'(ax1); y1 = 6'(ay1); width = 7'(aw); height = 6'(ah); color = acol;
    enable = 1'b1;

    n_wr = 0; n_start = 0; first_cyc = -1; start_cyc = -1; done_cyc = -1;
    wr_q.delete();
    for (int c = 1; c <= n_exp + 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        x1 = 7'd0; y1 = 6'd0; width = 7'd1; height = 6'd1; color = 16'h5A5A;
      end
      if (ram_write_enable) begin
        if (n_wr == 0) first_cyc = c;
        n_wr++;
        wr_q.push_back({8'(row), 8'(column), 8'(pixel), data_out});
      end
      if (ram_access_start) begin
        n_start++;
        start_cyc = c;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end

    k = 0;
    if (!empty) begin
      for (int r = ay1; r < ye; r++) begin
        for (int cc = ax1; cc < xe; cc++) begin
          for (int p = 1; p >= 0; p--) begin
            e = {8'(r), 8'(cc), 8'(p), (p == 1) ? acol[15:8] : acol[7:0]};
            if (k < wr_q.size()) chk($sformatf("%s_wr%0d", tag, k), wr_q[k], e);
            k++;
          end
        end
      end
    end
    chk({tag, "_count"}, 32'(n_wr), 32'(n_exp));
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(3 + n_exp));
    if (empty) begin
      chk({tag, "_start_cnt"}, 32'(n_start), 32'd0);
    end else begin
      chk({tag, "_first_cyc"}, 32'(first_cyc), 32'd3);
      chk({tag, "_start_cnt"}, 32'(n_start), 32'd1);
      chk({tag, "_start_cyc"}, 32'(start_cyc), 32'd3);
    end
  endtask

  // ack and enable drop together; done must clear and the block returns idle.
  task automatic release_op(input string tag);
    @(negedge clk);
    ack = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    chk({tag, "_rel_done"}, 32'(done), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int cnt_a, cnt_b;
    reset = 1'b1; enable = 1'b0; ack = 1'b0;
    x1 = '0; y1 = '0; width = '0; height = '0; color = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;

    // Basic fill
    run_fill("s1", 2, 3, 3, 2, 16'hABCD);
    chk("s1_count_hand", 32'(n_wr), 32'd12);
    chk("s1_first_hand", wr_q[0], 32'h030201AB);
    chk("s1_second_hand", wr_q[1], 32'h030200CD);
    chk("s1_last_hand", wr_q[11], 32'h040400CD);

    // Handshake: done held without ack, no restart while enable stays high
    cnt_a = 0; cnt_b = 0;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b1) cnt_a++;
      if (ram_write_enable !== 1'b0) cnt_b++;
    end
    chk("s4_done_held", 32'(cnt_a), 32'd0);
    chk("s4_no_we_held", 32'(cnt_b), 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("s4_done_clear", 32'(done), 32'd0);
    cnt_a = 0; cnt_b = 0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0) cnt_a++;
      if (ram_write_enable !== 1'b0 || ram_access_start !== 1'b0) cnt_b++;
    end
    chk("s4_no_redone", 32'(cnt_a), 32'd0);
    chk("s4_no_restart", 32'(cnt_b), 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);

    // Re-raised enable starts a new operation: clipping case
    run_fill("s2", 62, 31, 5, 4, 16'h1234);
    chk("s2_count_hand", 32'(n_wr), 32'd4);
    chk("s2_last_hand", wr_q[3], 32'h1F3F0034);
    release_op("s2");

    // Empty rectangles
    run_fill("s3w", 5, 5, 0, 3, 16'hFFFF);
    release_op("s3w");
    run_fill("s3h", 5, 5, 3, 0, 16'hFFFF);
    release_op("s3h");
    run_fill("s3x", 64, 5, 3, 3, 16'hFFFF);
    release_op("s3x");

    // Abort after the 5th write
    @(negedge clk);
    x1 = 7'd2; y1 = 6'd3; width = 7'd3; height = 6'd2; color = 16'hABCD;
    enable = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 20 && cnt_a < 5; c++) begin
      @(negedge clk);
      if (ram_write_enable) cnt_a++;
    end
    chk("s5_five_writes", 32'(cnt_a), 32'd5);
    enable = 1'b0;
    @(negedge clk);
    chk("s5_we_drop", 32'(ram_write_enable), 32'd0);
    cnt_a = 0; cnt_b = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0) cnt_a++;
      if (ram_write_enable !== 1'b0) cnt_b++;
    end
    chk("s5_no_done", 32'(cnt_a), 32'd0);
    chk("s5_no_we", 32'(cnt_b), 32'd0);

    // Fresh run after abort shows the block went back to idle
    run_fill("s5r", 2, 3, 3, 2, 16'hABCD);
    release_op("s5r");

    // Reset during WRITE
    @(negedge clk);
    x1 = 7'd2; y1 = 6'd3; width = 7'd3; height = 6'd2; color = 16'hABCD;
    enable = 1'b1;
    cnt_a = 0;
    for (int c = 0; c < 20 && cnt_a < 3; c++) begin
      @(negedge clk);
      if (ram_write_enable) cnt_a++;
    end
    chk("s6_three_writes", 32'(cnt_a), 32'd3);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk_idle_outputs("s6_reset");
    reset = 1'b0;
    @(negedge clk);
    run_fill("s6", 2, 3, 3, 2, 16'hABCD);
    chk("s6_last_hand", wr_q[11], 32'h040400CD);
    release_op("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
